tl_tx_arb_nch: RTL
==================

// Module: tl_tx_arb_nch
// PURPOSE
//  N-channel Transaction Layer TX arbiter between the per-class TLP queues (posted/NP/Cpl/...) and
//  the Data Link Layer. Grants whole packets only: header and data credits must both be available.
//  Priority is fixed by channel index, with a starvation counter per channel. Issues credit-consume
//  pulses to tl_credit_mgr, one set per granted packet.
// PARAMETERS
//  NUM_CH      3    number of request channels; index 0 = highest fixed priority (2..8)
//  STREAM_W    128  beat data width
//  LEN_W       10   TLP length field width in DW; value 0 encodes 2^LEN_W DW
//  CRD_W       12   data-credit count width (1 credit = 4 DW); must be >= LEN_W-1
//  STARVE_W    4    starvation counter width
//  STARVE_MAX  8    lost arbitrations before a channel is forced (1..2^STARVE_W-1)
// PORTS
//  clk                 in   1               clock
//  rst_n               in   1               async active-low reset
//  ch_data_i           in   NUM_CH*STREAM_W beat data, channel c at [c*STREAM_W +: STREAM_W]
//  ch_sop_i/ch_eop_i   in   NUM_CH          first/last beat of packet, per channel
//  ch_valid_i          in   NUM_CH          beat valid, per channel
//  ch_ready_o          out  NUM_CH          beat accepted, per channel
//  ch_has_data_i       in   NUM_CH          TLP carries payload; qualified by valid&sop
//  ch_len_dw_i         in   NUM_CH*LEN_W    payload length in DW; qualified by valid&sop
//  hdr_credit_ok_i     in   NUM_CH          header credit available for the channel's pool
//  data_credit_ok_i    in   NUM_CH          data credit available for the channel's pool
//  hdr_consume_v_o     out  NUM_CH          consume 1 header credit
//  data_consume_v_o    out  NUM_CH          consume data credits
//  data_consume_cr_o   out  NUM_CH*CRD_W    data credits to consume, channel c at [c*CRD_W +: CRD_W]
//  tx_data_o           out  STREAM_W        arbitrated beat to the DLL
//  tx_sop_o/tx_eop_o   out  1               first/last beat flags
//  tx_valid_o          out  1               beat valid
//  tx_ready_i          in   1               DLL accepts beat
//  grant_o             out  NUM_CH          one-hot owner; 0 when idle
//  sop_err_o           out  1               1-cycle pulse: non-SOP beat dropped while idle
// BEHAVIOUR
//  - Reset (async, any time incl. mid-packet): FSM=IDLE, starvation counters=0. All outputs 0.
//    The partial packet is abandoned.
//  - elig[c] = ch_valid_i[c] & ch_sop_i[c] & hdr_credit_ok_i[c]
//              & (!ch_has_data_i[c] | data_credit_ok_i[c]).
//  - FSM IDLE:
//    - If any elig, choose a winner combinationally and register grant_o.
//    - Next state is XFER; the first beat can pass in the next cycle.
//  - Winner selection:
//    - If any eligible channel has wait_cnt >= STARVE_MAX, the lowest-index such channel wins.
//    - Otherwise the lowest-index eligible channel wins.
//  - Starvation counters, on each grant:
//    - winner: cleared to 0;
//    - other eligible channels: +1, saturating at 2^STARVE_W-1;
//    - ineligible channels: hold.
//  - Stray beats in IDLE:
//    - If ch_valid_i[c] & !ch_sop_i[c] and no channel is elig, ch_ready_o[c]=1 for that cycle.
//      The beat is dropped and sop_err_o pulses.
//    - If several channels have stray beats, only the lowest index is dropped per cycle.
//  - FSM XFER, owner g:
//    - tx_data_o/tx_sop_o/tx_eop_o/tx_valid_o = channel g, combinational mux.
//    - ch_ready_o[g] = tx_ready_i; all other ch_ready_o = 0.
//    - On tx_valid_o & tx_ready_i & tx_eop_o: next state IDLE, grant_o=0.
//    - Gap between packets is exactly 1 idle cycle. No re-arbitration before EOP; packets are atomic.
//    - tx_ready_i low: beat, flags and grant held unchanged, for any duration.
//  - Credit consume:
//    - Registered 1-cycle pulses, asserted in the first XFER cycle only.
//    - Values come from the sideband sampled at the grant edge.
//    - hdr_consume_v_o[g]=1.
//    - If has_data: data_consume_v_o[g]=1 and data_consume_cr_o[g] = ceil(len/4) = (L+3)>>2.
//      L = len, or 2^LEN_W when len==0. Compute in LEN_W+2 bits, zero-extend to CRD_W.
//    - If !has_data: data_consume_v_o[g]=0 and data_consume_cr_o[g]=0.
//    - The credit manager therefore updates before the next IDLE decision; no double-spend.
//  - Credits are checked only at grant. A credit_ok drop during XFER does not stall the packet.
//  - If ch_valid_i[g] drops mid-packet, tx_valid_o=0 for that cycle; this is not an error.
// TESTING
//  1. ch1 only; 3-beat packet, has_data=1, len=5 -> grant_o=0b010 one cycle later; 3 beats pass
//     in order; hdr_consume_v_o[1] and data_consume_v_o[1] pulse once with cr=2.
//  2. ch0 and ch2 eligible in the same cycle, 1-beat packets -> ch0 sent, 1 idle cycle, then ch2.
//  3. STARVE_MAX=3; ch0 continuously eligible, ch2 eligible -> ch2 wins the 4th arbitration, then
//     ch0 resumes; ch2 counter reads 0.
//  4. ch0 has_data=1 with data_credit_ok_i[0]=0, ch1 no-data eligible -> ch1 granted, ch0 waits;
//     raise data_credit_ok_i[0] -> ch0 granted next IDLE.
//  5. tx_ready_i low for 5 cycles on beat 2 of 4 -> tx_data_o stable, grant_o unchanged,
//     ch_ready_o all 0; resume -> beats 2..4 delivered once each.
//  6. has_data=1, len=0 -> cr=256. ch2 valid with sop=0 in IDLE -> beat dropped, sop_err_o=1 for
//     1 cycle. rst_n low mid-packet -> all outputs 0 and counters 0 immediately.

Source files
------------

// File: rtl/tl_tx_arb_nch.sv
// tl_tx_arb_nch: N-channel TLP transmit arbiter in front of the Data Link Layer.
// Grants whole packets only, and only when header credit and (for payload TLPs) data credit
// are both available. Fixed priority by channel index, overridden by per-channel starvation
// counters. Emits one set of credit-consume pulses per granted packet.
//
// Ports
//   clk, rst_n           clock, async active-low reset
//   ch_data_i            per-channel beat data, channel c at [c*STREAM_W +: STREAM_W]
//   ch_sop_i/ch_eop_i    per-channel first/last beat flags
//   ch_valid_i           per-channel beat valid
//   ch_ready_o           per-channel beat accepted (combinational)
//   ch_has_data_i        TLP carries payload (valid with sop)
//   ch_len_dw_i          payload length in DW, 0 encodes 2^LEN_W (valid with sop)
//   hdr_credit_ok_i      header credit available per channel pool
//   data_credit_ok_i     data credit available per channel pool
//   hdr_consume_v_o      consume one header credit (registered pulse)
//   data_consume_v_o     consume data credits (registered pulse)
//   data_consume_cr_o    data credits to consume, channel c at [c*CRD_W +: CRD_W]
//   tx_data_o/sop/eop/valid  arbitrated beat to the DLL (combinational mux)
//   tx_ready_i           DLL accepts beat
//   grant_o              one-hot current owner, 0 when idle
//   sop_err_o            pulse: a non-SOP beat was dropped while idle
module tl_tx_arb_nch #(
   parameter int unsigned NUM_CH     = 3,
   parameter int unsigned STREAM_W   = 128,
   parameter int unsigned LEN_W      = 10,
   parameter int unsigned CRD_W      = 12,
   parameter int unsigned STARVE_W   = 4,
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_CH*STREAM_W-1:0] ch_data_i,
   input  logic [NUM_CH-1:0]          ch_sop_i,
   input  logic [NUM_CH-1:0]          ch_eop_i,
   input  logic [NUM_CH-1:0]          ch_valid_i,
   output logic [NUM_CH-1:0]          ch_ready_o,
   input  logic [NUM_CH-1:0]          ch_has_data_i,
   input  logic [NUM_CH*LEN_W-1:0]    ch_len_dw_i,
   input  logic [NUM_CH-1:0]          hdr_credit_ok_i,
   input  logic [NUM_CH-1:0]          data_credit_ok_i,
   output logic [NUM_CH-1:0]          hdr_consume_v_o,
   output logic [NUM_CH-1:0]          data_consume_v_o,
   output logic [NUM_CH*CRD_W-1:0]    data_consume_cr_o,
   output logic [STREAM_W-1:0]        tx_data_o,
   output logic                       tx_sop_o,
   output logic                       tx_eop_o,
   output logic                       tx_valid_o,
   input  logic                       tx_ready_i,
   output logic [NUM_CH-1:0]          grant_o,
   output logic                       sop_err_o
);

   localparam int unsigned           LW2     = LEN_W + 2;
   localparam logic [STARVE_W-1:0]   CNT_SAT = '1;
   localparam logic [STARVE_W-1:0]   CNT_LIM = STARVE_W'(STARVE_MAX);

   typedef enum logic {IDLE, XFER} state_e;

   state_e                           state_q, state_d;
   logic [NUM_CH-1:0]                grant_q, grant_d;
   logic [NUM_CH-1:0][STARVE_W-1:0]  wait_q, wait_d;
   logic [NUM_CH-1:0]                hdr_v_q, hdr_v_d;
   logic [NUM_CH-1:0]                dat_v_q, dat_v_d;
   logic [NUM_CH-1:0][CRD_W-1:0]     cr_q, cr_d;
   logic [NUM_CH-1:0][CRD_W-1:0]     crd_c;
   logic                             sop_err_q, sop_err_d;
   logic                             run_q;
   logic [NUM_CH-1:0]                elig_c, starved_c, win_c, stray_c, drop_c;

   // Isolate the lowest set bit.
   function automatic logic [NUM_CH-1:0] lowest_one(input logic [NUM_CH-1:0] v);
      lowest_one = v & (~v + NUM_CH'(1));
   endfunction

   // Eligibility and winner selection; starved channels pre-empt fixed priority.
   always_comb begin
      elig_c    = ch_valid_i & ch_sop_i & hdr_credit_ok_i & (~ch_has_data_i | data_credit_ok_i);
      stray_c   = ch_valid_i & ~ch_sop_i;
      starved_c = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         starved_c[c] = elig_c[c] && (wait_q[c] >= CNT_LIM);
      end
      win_c  = lowest_one((|starved_c) ? starved_c : elig_c);
      drop_c = lowest_one(stray_c);
   end

   // Data credits per channel: ceil(L/4), with len==0 meaning 2^LEN_W DW.
   always_comb begin
      logic [LEN_W-1:0] len_l;
      logic [LW2-1:0]   tot;
      len_l = '0;
      tot   = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         len_l    = ch_len_dw_i[c*LEN_W +: LEN_W];
         tot      = (len_l == '0) ? (LW2'(1) << LEN_W) : LW2'(len_l);
         crd_c[c] = CRD_W'((tot + LW2'(3)) >> 2);
      end
   end

   // Starvation counters move only on a grant.
   always_comb begin
      wait_d = wait_q;
      if ((state_q == IDLE) && (|elig_c)) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (win_c[c]) begin
               wait_d[c] = '0;
            end else if (elig_c[c] && (wait_q[c] != CNT_SAT)) begin
               wait_d[c] = wait_q[c] + STARVE_W'(1);
            end
         end
      end
   end

   // Beat mux from the current owner; all zero when nothing is granted.
   always_comb begin
      tx_data_o  = '0;
      tx_sop_o   = 1'b0;
      tx_eop_o   = 1'b0;
      tx_valid_o = 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (grant_q[c]) begin
            tx_data_o  = ch_data_i[c*STREAM_W +: STREAM_W];
            tx_sop_o   = ch_sop_i[c];
            tx_eop_o   = ch_eop_i[c];
            tx_valid_o = ch_valid_i[c];
         end
      end
   end

   // Next state, grant and credit-consume pulses.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      hdr_v_d    = '0;
      dat_v_d    = '0;
      cr_d       = '0;
      sop_err_d  = 1'b0;
      ch_ready_o = '0;
      case (state_q)
         IDLE: begin
            if (|elig_c) begin
               state_d = XFER;
               grant_d = win_c;
               hdr_v_d = win_c;
               dat_v_d = win_c & ch_has_data_i;
               for (int unsigned c = 0; c < NUM_CH; c++) begin
                  if (win_c[c] && ch_has_data_i[c]) cr_d[c] = crd_c[c];
               end
            end else if (run_q && (|stray_c)) begin
               // run_q keeps stray drops from showing on ch_ready_o while in reset.
               ch_ready_o = drop_c;
               sop_err_d  = 1'b1;
            end
         end
         XFER: begin
            ch_ready_o = grant_q & {NUM_CH{tx_ready_i}};
            if (tx_valid_o && tx_ready_i && tx_eop_o) begin
               state_d = IDLE;
               grant_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         wait_q    <= '0;
         hdr_v_q   <= '0;
         dat_v_q   <= '0;
         cr_q      <= '0;
         sop_err_q <= 1'b0;
         run_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         wait_q    <= wait_d;
         hdr_v_q   <= hdr_v_d;
         dat_v_q   <= dat_v_d;
         cr_q      <= cr_d;
         sop_err_q <= sop_err_d;
         run_q     <= 1'b1;
      end
   end

   assign grant_o           = grant_q;
   assign hdr_consume_v_o   = hdr_v_q;
   assign data_consume_v_o  = dat_v_q;
   assign data_consume_cr_o = cr_q;
   assign sop_err_o         = sop_err_q;

endmodule
